// File: rtl/trainerror_responder.sv
// trainerror_responder: responder side of the LTSM TRAINERROR sideband handshake.
// Waits for {TRAINERROR Entry req} on RX, answers with {TRAINERROR Entry resp} on TX,
// then flags completion until enable_i falls.
// Optional request timeout: define TRAINERROR_RESP_TIMEOUT_EN.

package SB_codex_pkg;
    localparam int unsigned CODE_W = 8;

    // Sideband message payload
    typedef struct packed {
        logic [CODE_W-1:0] msg_code;
        logic [7:0]        msg_subcode;
        logic [15:0]       msg_info;
    } SB_msg_t;

    localparam logic [CODE_W-1:0] TRAINERROR_ENTRY_REQ  = 8'h15;
    localparam logic [CODE_W-1:0] TRAINERROR_ENTRY_RESP = 8'h19;
endpackage

module trainerror_responder
    import SB_codex_pkg::*;
#(
    parameter logic [CODE_W-1:0] REQ_CODE       = TRAINERROR_ENTRY_REQ,
    parameter logic [CODE_W-1:0] RESP_CODE      = TRAINERROR_ENTRY_RESP,
    parameter int unsigned       TIMEOUT_CYCLES = 800000
) (
    input  logic    clk_100MHz,
    input  logic    reset,
    input  logic    enable_i,
    output logic    TRAINERROR_done_o,
    output SB_msg_t TX_msg_o,
    output logic    TX_msg_valid_o,
    input  logic    TX_msg_valid_ack_i,
    input  SB_msg_t RX_msg_i,
    input  logic    RX_msg_valid_i,
    output logic    RX_msg_req_o,
    output logic    reset_state_timeout_counter_o,
    output logic    timeout_o
);

    typedef enum logic [1:0] {IDLE, WAIT_REQ, SEND_RESP, DONE} state_t;

    state_t  state;
    state_t  next_state;
    logic    req_match;
    logic    expired;
    logic    done_d;
    logic    tx_valid_d;
    logic    rx_req_d;
    logic    restart_d;
    SB_msg_t tx_msg_d;
    logic    rx_fields_unused;

    // Only the message code identifies the request; the other RX fields are ignored
    assign rx_fields_unused = ^{RX_msg_i.msg_subcode, RX_msg_i.msg_info};

    // A message is consumed whenever we request one and RX offers one
    assign req_match = RX_msg_valid_i && RX_msg_req_o && (RX_msg_i.msg_code == REQ_CODE);

`ifdef TRAINERROR_RESP_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Request wait budget: counts WAIT_REQ cycles, zero everywhere else
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state != WAIT_REQ) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign expired = (state == WAIT_REQ) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Timeout pulse accompanies the WAIT_REQ -> DONE move
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= (state == WAIT_REQ) && (next_state == DONE);
        end
    end
`else
    logic [31:0] timeout_cfg_unused;

    assign timeout_cfg_unused = 32'(TIMEOUT_CYCLES);
    assign expired            = 1'b0;
    assign timeout_o          = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; dropping enable_i overrides everything, including a same-cycle ack
    always_comb begin
        next_state = state;
        if (!enable_i) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:      next_state = WAIT_REQ;
                WAIT_REQ: begin
                    if (req_match) begin
                        next_state = SEND_RESP;
                    end else if (expired) begin
                        next_state = DONE;
                    end
                end
                SEND_RESP: begin
                    if (TX_msg_valid_ack_i) begin
                        next_state = DONE;
                    end
                end
                DONE:      next_state = DONE;
                default:   next_state = IDLE;
            endcase
        end
    end

    // Output decode from the upcoming state so every output is a flop
    always_comb begin
        done_d     = 1'b0;
        tx_valid_d = 1'b0;
        rx_req_d   = 1'b0;
        tx_msg_d   = '0;
        restart_d  = ((state == IDLE) && (next_state == WAIT_REQ)) ||
                     ((state == WAIT_REQ) && (next_state == SEND_RESP));
        case (next_state)
            WAIT_REQ:  rx_req_d = 1'b1;
            SEND_RESP: begin
                tx_valid_d        = 1'b1;
                tx_msg_d.msg_code = RESP_CODE;
            end
            DONE:      done_d = 1'b1;
            default:   ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            TRAINERROR_done_o             <= 1'b0;
            TX_msg_valid_o                <= 1'b0;
            TX_msg_o                      <= '0;
            RX_msg_req_o                  <= 1'b0;
            reset_state_timeout_counter_o <= 1'b0;
        end else begin
            TRAINERROR_done_o             <= done_d;
            TX_msg_valid_o                <= tx_valid_d;
            TX_msg_o                      <= tx_msg_d;
            RX_msg_req_o                  <= rx_req_d;
            reset_state_timeout_counter_o <= restart_d;
        end
    end

endmodule

// File: tb/tb_trainerror_responder.sv
// Testbench for trainerror_responder: directed handshake scenarios plus a randomized
// run checked against a flag-based model of the handshake rules.
module tb_trainerror_responder;
    import SB_codex_pkg::*;

    localparam int unsigned TO_CYCLES = 16;

    logic    clk = 1'b0;
    logic    reset;
    logic    enable_i;
    logic    TRAINERROR_done_o;
    SB_msg_t TX_msg_o;
    logic    TX_msg_valid_o;
    logic    TX_msg_valid_ack_i;
    SB_msg_t RX_msg_i;
    logic    RX_msg_valid_i;
    logic    RX_msg_req_o;
    logic    reset_state_timeout_counter_o;
    logic    timeout_o;

    int n_checks = 0;
    int n_fail   = 0;

    SB_msg_t resp_msg;

    // Model state: started handshake, request received, handshake finished
    bit      m_active;
    bit      m_got;
    bit      m_done;
    int      m_cnt;
    logic [4:0] exp_outs;
    SB_msg_t exp_msg;

`ifdef TRAINERROR_RESP_TIMEOUT_EN
    trainerror_responder #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
`else
    trainerror_responder dut (
`endif
        .clk_100MHz                    (clk),
        .reset                         (reset),
        .enable_i                      (enable_i),
        .TRAINERROR_done_o             (TRAINERROR_done_o),
        .TX_msg_o                      (TX_msg_o),
        .TX_msg_valid_o                (TX_msg_valid_o),
        .TX_msg_valid_ack_i            (TX_msg_valid_ack_i),
        .RX_msg_i                      (RX_msg_i),
        .RX_msg_valid_i                (RX_msg_valid_i),
        .RX_msg_req_o                  (RX_msg_req_o),
        .reset_state_timeout_counter_o (reset_state_timeout_counter_o),
        .timeout_o                     (timeout_o)
    );

    always #5 clk = ~clk;

    // {done, tx_valid, rx_req, restart_pulse, timeout}
    function automatic logic [4:0] outs();
        return {TRAINERROR_done_o, TX_msg_valid_o, RX_msg_req_o,
                reset_state_timeout_counter_o, timeout_o};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_code(input logic [7:0] code);
        RX_msg_i          = '0;
        RX_msg_i.msg_code = code;
        RX_msg_valid_i    = 1'b1;
    endtask

    task automatic quiet_inputs();
        RX_msg_i           = '0;
        RX_msg_valid_i     = 1'b0;
        TX_msg_valid_ack_i = 1'b0;
    endtask

    // Apply the handshake rules to the current inputs and predict outputs after the edge
    task automatic model_cycle();
        bit pulse;
        bit to;
        pulse = 1'b0;
        to    = 1'b0;
        if (reset || !enable_i) begin
            m_active = 1'b0;
            m_got    = 1'b0;
            m_done   = 1'b0;
            m_cnt    = 0;
        end else if (!m_active) begin
            m_active = 1'b1;
            m_cnt    = 0;
            pulse    = 1'b1;
        end else if (!m_got && !m_done) begin
            if (RX_msg_valid_i && RX_msg_i.msg_code == TRAINERROR_ENTRY_REQ) begin
                m_got = 1'b1;
                pulse = 1'b1;
            end
`ifdef TRAINERROR_RESP_TIMEOUT_EN
            else if (m_cnt == int'(TO_CYCLES) - 1) begin
                m_done = 1'b1;
                to     = 1'b1;
            end else begin
                m_cnt++;
            end
`endif
        end else if (m_got && !m_done) begin
            if (TX_msg_valid_ack_i) m_done = 1'b1;
        end
        exp_outs = {m_done, m_got && !m_done, m_active && !m_got && !m_done, pulse, to};
        exp_msg  = (m_got && !m_done) ? resp_msg : SB_msg_t'(0);
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        enable_i = 1'b1;
        quiet_inputs();
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (outs() !== 5'b00000 || TX_msg_o !== SB_msg_t'(0)) begin
                n_fail++;
                $display("FAIL reset_outs[%0d]: got %b msg %h, want 00000 msg 0", i, outs(), TX_msg_o);
            end
        end
        reset = 1'b0;
        step();
        n_checks++;
        if (outs() !== 5'b00110) begin
            n_fail++;
            $display("FAIL reset_release_req: got %b, want 00110", outs());
        end
        step();
        n_checks++;
        if (outs() !== 5'b00100) begin
            n_fail++;
            $display("FAIL reset_wait_req: got %b, want 00100", outs());
        end
    endtask

    task automatic test_basic();
        send_code(TRAINERROR_ENTRY_REQ);
        step();
        quiet_inputs();
        n_checks++;
        if (outs() !== 5'b01010 || TX_msg_o !== resp_msg) begin
            n_fail++;
            $display("FAIL basic_resp: got %b msg %h, want 01010 msg %h", outs(), TX_msg_o, resp_msg);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (outs() !== 5'b01000 || TX_msg_o !== resp_msg) begin
                n_fail++;
                $display("FAIL basic_hold[%0d]: got %b msg %h, want 01000 msg %h", i, outs(), TX_msg_o, resp_msg);
            end
        end
        TX_msg_valid_ack_i = 1'b1;
        step();
        TX_msg_valid_ack_i = 1'b0;
        n_checks++;
        if (outs() !== 5'b10000 || TX_msg_o !== SB_msg_t'(0)) begin
            n_fail++;
            $display("FAIL basic_done: got %b msg %h, want 10000 msg 0", outs(), TX_msg_o);
        end
        // A request arriving in DONE is ignored
        send_code(TRAINERROR_ENTRY_REQ);
        step();
        quiet_inputs();
        n_checks++;
        if (outs() !== 5'b10000) begin
            n_fail++;
            $display("FAIL basic_done_hold: got %b, want 10000", outs());
        end
        enable_i = 1'b0;
        step();
        n_checks++;
        if (outs() !== 5'b00000) begin
            n_fail++;
            $display("FAIL basic_disable: got %b, want 00000", outs());
        end
    endtask

    task automatic test_nonmatching();
        enable_i = 1'b1;
        step();
        send_code(8'h3c);
        step();
        n_checks++;
        if (outs() !== 5'b00100) begin
            n_fail++;
            $display("FAIL nonmatch_first: got %b, want 00100", outs());
        end
        send_code(8'h16);
        step();
        n_checks++;
        if (outs() !== 5'b00100) begin
            n_fail++;
            $display("FAIL nonmatch_second: got %b, want 00100", outs());
        end
        send_code(TRAINERROR_ENTRY_REQ);
        step();
        quiet_inputs();
        n_checks++;
        if (outs() !== 5'b01010 || TX_msg_o !== resp_msg) begin
            n_fail++;
            $display("FAIL nonmatch_resp: got %b msg %h, want 01010 msg %h", outs(), TX_msg_o, resp_msg);
        end
        TX_msg_valid_ack_i = 1'b1;
        step();
        TX_msg_valid_ack_i = 1'b0;
        n_checks++;
        if (outs() !== 5'b10000) begin
            n_fail++;
            $display("FAIL nonmatch_done: got %b, want 10000", outs());
        end
        enable_i = 1'b0;
        step();
    endtask

    task automatic test_abort_on_ack();
        enable_i = 1'b1;
        step();
        send_code(TRAINERROR_ENTRY_REQ);
        step();
        quiet_inputs();
        TX_msg_valid_ack_i = 1'b1;
        enable_i           = 1'b0;
        step();
        TX_msg_valid_ack_i = 1'b0;
        n_checks++;
        if (outs() !== 5'b00000 || TX_msg_o !== SB_msg_t'(0)) begin
            n_fail++;
            $display("FAIL abort_ack: got %b msg %h, want 00000 msg 0", outs(), TX_msg_o);
        end
        step();
        n_checks++;
        if (outs() !== 5'b00000) begin
            n_fail++;
            $display("FAIL abort_stay_idle: got %b, want 00000", outs());
        end
        enable_i = 1'b1;
        step();
        n_checks++;
        if (outs() !== 5'b00110) begin
            n_fail++;
            $display("FAIL abort_reentry: got %b, want 00110", outs());
        end
    endtask

    task automatic test_mid_reset();
        send_code(TRAINERROR_ENTRY_REQ);
        step();
        quiet_inputs();
        reset = 1'b1;
        step();
        n_checks++;
        if (outs() !== 5'b00000 || TX_msg_o !== SB_msg_t'(0)) begin
            n_fail++;
            $display("FAIL mid_reset: got %b msg %h, want 00000 msg 0", outs(), TX_msg_o);
        end
        reset = 1'b0;
        step();
        n_checks++;
        if (outs() !== 5'b00110) begin
            n_fail++;
            $display("FAIL mid_reset_restart: got %b, want 00110", outs());
        end
        enable_i = 1'b0;
        step();
    endtask

`ifdef TRAINERROR_RESP_TIMEOUT_EN
    task automatic test_timeout();
        enable_i = 1'b1;
        step();
        for (int i = 1; i < int'(TO_CYCLES); i++) begin
            step();
            n_checks++;
            if (outs() !== 5'b00100) begin
                n_fail++;
                $display("FAIL timeout_wait[%0d]: got %b, want 00100", i, outs());
            end
        end
        step();
        n_checks++;
        if (outs() !== 5'b10001) begin
            n_fail++;
            $display("FAIL timeout_expire: got %b, want 10001", outs());
        end
        step();
        n_checks++;
        if (outs() !== 5'b10000) begin
            n_fail++;
            $display("FAIL timeout_pulse_end: got %b, want 10000", outs());
        end
        enable_i = 1'b0;
        step();
    endtask

    task automatic test_timeout_race();
        enable_i = 1'b1;
        step();
        for (int i = 1; i < int'(TO_CYCLES); i++) step();
        send_code(TRAINERROR_ENTRY_REQ);
        step();
        quiet_inputs();
        n_checks++;
        if (outs() !== 5'b01010 || TX_msg_o !== resp_msg) begin
            n_fail++;
            $display("FAIL timeout_race: got %b msg %h, want 01010 msg %h", outs(), TX_msg_o, resp_msg);
        end
        enable_i = 1'b0;
        step();
    endtask
`endif

    task automatic test_random();
        logic [7:0] code;
        reset = 1'b1;
        quiet_inputs();
        model_cycle();
        step();
        reset = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            reset              = ($urandom_range(0, 199) == 0);
            enable_i           = ($urandom_range(0, 19) != 0);
            RX_msg_valid_i     = ($urandom_range(0, 2) == 0);
            TX_msg_valid_ack_i = ($urandom_range(0, 2) == 0);
            code = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 0) code = TRAINERROR_ENTRY_REQ;
            else if (code == TRAINERROR_ENTRY_REQ) code = code ^ 8'h01;
            RX_msg_i.msg_code    = code;
            RX_msg_i.msg_subcode = 8'($urandom);
            RX_msg_i.msg_info    = 16'($urandom);
            model_cycle();
            step();
            n_checks++;
            if (outs() !== exp_outs || TX_msg_o !== exp_msg) begin
                n_fail++;
                $display("FAIL random[%0d]: got %b msg %h, want %b msg %h", i, outs(), TX_msg_o, exp_outs, exp_msg);
            end
        end
        quiet_inputs();
        enable_i = 1'b0;
        reset    = 1'b0;
        step();
    endtask

    initial begin
        resp_msg          = '0;
        resp_msg.msg_code = TRAINERROR_ENTRY_RESP;
        test_reset();
        test_basic();
        test_nonmatching();
        test_abort_on_ack();
        enable_i = 1'b1;
        step();
        test_mid_reset();
`ifdef TRAINERROR_RESP_TIMEOUT_EN
        test_timeout();
        test_timeout_race();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
